// File: rtl/seg7_scan_ctrl_pkg.sv
// Shared definitions for the 7-segment scan controller.
//   nibble_t   : one hex/BCD digit as presented to the shared decoder
//   SEG_BLANK  : all segments off (active-low pins)
//   DP_OFF     : decimal point off (active-low pin)
//   width_of() : counter width for a given limit, never narrower than 1 bit
package seg7_scan_ctrl_pkg;

    typedef logic [3:0] nibble_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic       DP_OFF    = 1'b1;

    function automatic int width_of(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/seg7_scan_ctrl_if.sv
// Display-side bundle of the scan controller.
//   digits/dp_in/blink_mask/lz_blank_en : what the timekeeping logic wants shown
//   seg_code -> external seg7dec -> dec_in : shared decoder loop
//   seg_out/dp_out/an_out              : display pins, all active-low
//   frame_tick                         : one-cycle pulse on the last cycle of a frame
// master = scan controller, slave = its surroundings (counters, decoder, pins).
interface seg7_scan_ctrl_if #(
    parameter int NDIG = 6
);
    logic [4*NDIG-1:0] digits;
    logic [NDIG-1:0]   dp_in;
    logic [NDIG-1:0]   blink_mask;
    logic              lz_blank_en;
    logic [3:0]        seg_code;
    logic [6:0]        dec_in;
    logic [6:0]        seg_out;
    logic              dp_out;
    logic [NDIG-1:0]   an_out;
    logic              frame_tick;

    modport master (
        input  digits, dp_in, blink_mask, lz_blank_en, dec_in,
        output seg_code, seg_out, dp_out, an_out, frame_tick
    );

    modport slave (
        output digits, dp_in, blink_mask, lz_blank_en, dec_in,
        input  seg_code, seg_out, dp_out, an_out, frame_tick
    );

endinterface

// File: rtl/seg7_scan_timer.sv
// Slot/frame timebase for the scan controller.
//   clk, rst_n  : system clock, async active-low reset
//   idx         : digit currently being scanned (0 = rightmost)
//   slot_start  : cnt == 0
//   seg_latch   : cnt == BLANK_CYC-1 (decoder output is settled here)
//   on_start    : cnt == BLANK_CYC (first cycle an anode may be driven)
//   frame_end   : last cycle of the last digit slot
//   blink_wrap  : frame_end of the last frame in a blink half-period
// All strobes are decoded from the current counter value, so they are
// valid during the cycle whose edge they act on.
module seg7_scan_timer
    import seg7_scan_ctrl_pkg::*;
#(
    parameter int NDIG         = 6,
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYC    = 500,
    parameter int BLINK_FRAMES = 64,
    parameter int IDX_W        = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [IDX_W-1:0] idx,
    output logic             slot_start,
    output logic             seg_latch,
    output logic             on_start,
    output logic             frame_end,
    output logic             blink_wrap
);

    localparam int CNT_W = width_of(SCAN_DIV);
    localparam int FRM_W = width_of(BLINK_FRAMES);

    logic [CNT_W-1:0] cnt;
    logic [FRM_W-1:0] frame_cnt;
    logic             slot_end;

    assign slot_start = (cnt == '0);
    assign seg_latch  = (cnt == CNT_W'(BLANK_CYC - 1));
    assign on_start   = (cnt == CNT_W'(BLANK_CYC));
    assign slot_end   = (cnt == CNT_W'(SCAN_DIV - 1));
    assign frame_end  = slot_end && (idx == IDX_W'(NDIG - 1));
    assign blink_wrap = frame_end && (frame_cnt == FRM_W'(BLINK_FRAMES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            idx       <= '0;
            frame_cnt <= '0;
        end else begin
            if (slot_end) begin
                cnt <= '0;
                idx <= frame_end ? '0 : idx + IDX_W'(1);
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
            if (frame_end) begin
                frame_cnt <= blink_wrap ? '0 : frame_cnt + FRM_W'(1);
            end
        end
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan controller for an NDIG-digit common-anode display.
//   clk, rst_n : system clock, async active-low reset
//   bus        : seg7_scan_ctrl_if.master (digit inputs, shared decoder loop,
//                active-low segment/dp/anode pins, frame_tick)
// Each slot is SCAN_DIV cycles: BLANK_CYC dead cycles with every anode off,
// then the selected anode on (unless the digit is blanked or blinked off).
// The inputs are snapshotted once per frame so a frame is always coherent.
//
// state    | meaning
// ---------+---------------------------------------------------
// ST_BLANK | dead time, all anodes off, decoder settling
// ST_ON    | anode of digit idx driven low if the digit is lit
module seg7_scan_ctrl
    import seg7_scan_ctrl_pkg::*;
#(
    parameter int NDIG         = 6,
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYC    = 500,
    parameter int BLINK_FRAMES = 64
) (
    input logic              clk,
    input logic              rst_n,
    seg7_scan_ctrl_if.master bus
);

    localparam int IDX_W = width_of(NDIG);

    localparam logic [0:0] ST_BLANK = 1'b0;
    localparam logic [0:0] ST_ON    = 1'b1;

    logic [IDX_W-1:0] idx;
    logic             slot_start;
    logic             seg_latch;
    logic             on_start;
    logic             frame_end;
    logic             blink_wrap;
    logic             frame_start;

    logic [0:0]       state;
    logic [0:0]       state_nxt;

    nibble_t          snap [NDIG];
    logic [NDIG-1:0]  dp_snap;
    logic [NDIG-1:0]  blink_snap;
    logic             lz_en_snap;
    logic             blink_phase;

    logic [NDIG-1:0]  lit;
    logic [NDIG-1:0]  an_nxt;

    logic [3:0]       seg_code_q;
    logic [6:0]       seg_out_q;
    logic             dp_out_q;
    logic [NDIG-1:0]  an_out_q;
    logic             frame_tick_q;

    seg7_scan_timer #(
        .NDIG         (NDIG),
        .SCAN_DIV     (SCAN_DIV),
        .BLANK_CYC    (BLANK_CYC),
        .BLINK_FRAMES (BLINK_FRAMES),
        .IDX_W        (IDX_W)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .idx        (idx),
        .slot_start (slot_start),
        .seg_latch  (seg_latch),
        .on_start   (on_start),
        .frame_end  (frame_end),
        .blink_wrap (blink_wrap)
    );

    assign frame_start = slot_start && (idx == '0);

    always_comb begin
        state_nxt = state;
        if (slot_start) begin
            state_nxt = ST_BLANK;
        end else if (on_start) begin
            state_nxt = ST_ON;
        end
    end

    // Walk from the most significant digit down: a digit is a leading zero
    // while it and everything above it are zero. Digit 0 always shows.
    always_comb begin
        logic run_zero;
        run_zero = 1'b1;
        lit      = '0;
        for (int i = NDIG - 1; i >= 0; i--) begin
            run_zero = run_zero && (snap[i] == 4'h0);
            lit[i]   = !(lz_en_snap && (i != 0) && run_zero) &&
                       !(blink_snap[i] && blink_phase);
        end
    end

    always_comb begin
        an_nxt = '1;
        if (state_nxt == ST_ON && lit[idx]) begin
            an_nxt[idx] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_BLANK;
            for (int i = 0; i < NDIG; i++) begin
                snap[i] <= '0;
            end
            dp_snap      <= '0;
            blink_snap   <= '0;
            lz_en_snap   <= 1'b0;
            blink_phase  <= 1'b0;
            seg_code_q   <= '0;
            seg_out_q    <= SEG_BLANK;
            dp_out_q     <= DP_OFF;
            an_out_q     <= '1;
            frame_tick_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (frame_start) begin
                for (int i = 0; i < NDIG; i++) begin
                    snap[i] <= bus.digits[4*i +: 4];
                end
                dp_snap    <= bus.dp_in;
                blink_snap <= bus.blink_mask;
                lz_en_snap <= bus.lz_blank_en;
            end
            // Digit 0 is fetched on the same edge as the snapshot, so take
            // it straight from the input rather than the stale snapshot.
            if (slot_start) begin
                seg_code_q <= frame_start ? bus.digits[3:0] : snap[idx];
            end
            if (seg_latch) begin
                seg_out_q <= bus.dec_in;
                dp_out_q  <= ~dp_snap[idx];
            end
            an_out_q     <= an_nxt;
            frame_tick_q <= frame_end;
            if (blink_wrap) begin
                blink_phase <= ~blink_phase;
            end
        end
    end

    assign bus.seg_code   = seg_code_q;
    assign bus.seg_out    = seg_out_q;
    assign bus.dp_out     = dp_out_q;
    assign bus.an_out     = an_out_q;
    assign bus.frame_tick = frame_tick_q;

endmodule
